// File: rtl/minibyte_gendemux_reg.sv
// minibyte_gendemux_reg: registered 1-to-2 demux steering one byte stream into two valid/ready holding channels
module minibyte_gendemux_reg #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 valid_in,
  input  logic                 sel_in,
  output logic                 ready_out,
  output logic [WIDTH-1:0]     a_data_out,
  output logic                 a_valid_out,
  input  logic                 a_ready_in,
  output logic [WIDTH-1:0]     b_data_out,
  output logic                 b_valid_out,
  input  logic                 b_ready_in,
  output logic [CNT_WIDTH-1:0] a_count_out,
  output logic [CNT_WIDTH-1:0] b_count_out
);
  logic w_fill_a, w_fill_b, w_drain_a, w_drain_b;
  always_comb begin
    ready_out = ~rst_in & (sel_in ? (~b_valid_out | b_ready_in) : (~a_valid_out | a_ready_in));
    w_fill_a  = valid_in & ready_out & ~sel_in;
    w_fill_b  = valid_in & ready_out & sel_in;
    w_drain_a = a_valid_out & a_ready_in;
    w_drain_b = b_valid_out & b_ready_in;
  end
  // a channel stays full when refilled in the same cycle it drains
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_valid_out <= 1'b0;
      b_valid_out <= 1'b0;
      a_data_out  <= '0;
      b_data_out  <= '0;
      a_count_out <= '0;
      b_count_out <= '0;
    end else begin
      a_valid_out <= w_fill_a | (a_valid_out & ~a_ready_in);
      b_valid_out <= w_fill_b | (b_valid_out & ~b_ready_in);
      if (w_fill_a) a_data_out <= data_in;
      if (w_fill_b) b_data_out <= data_in;
      if (w_drain_a) a_count_out <= a_count_out + 1'b1;
      if (w_drain_b) b_count_out <= b_count_out + 1'b1;
    end
  end
endmodule

// File: doc/minibyte_gendemux_reg.md
Name: minibyte_gendemux_reg

Overview:
- Registered 1-to-2 demultiplexer: the inverse of the generic 2:1 mux.
- Steers one 8-bit source stream into one of two destination channels (A/B) under sel_in.
- Each channel has a single-entry holding register with a valid/ready handshake.
- Used on the minibyte internal bus to route a shared result byte to one of two consumers, e.g. accumulator write-back vs. memory-write path, without a combinational path from source to consumer.

Parameters:
- WIDTH, 8, data width of source and both destination channels.
- CNT_WIDTH, 8, width of per-channel transfer counters.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- data_in  input  WIDTH  source data.
- valid_in  input  1  source data valid.
- sel_in  input  1  destination select: 0 = channel A, 1 = channel B; sampled only on accepted transfers.
- ready_out  output  1  source may transfer this cycle (combinational).
- a_data_out  output  WIDTH  channel A held data.
- a_valid_out  output  1  channel A holds data.
- a_ready_in  input  1  channel A consumer accepts.
- b_data_out  output  WIDTH  channel B held data.
- b_valid_out  output  1  channel B holds data.
- b_ready_in  input  1  channel B consumer accepts.
- a_count_out  output  CNT_WIDTH  completed channel A output handshakes, wrapping.
- b_count_out  output  CNT_WIDTH  completed channel B output handshakes, wrapping.

Behaviour:
- Reset: clock is clk_in; reset is rst_in, synchronous, active-high. While rst_in=1 at a rising edge, all state clears:
  - a_valid_out=0, b_valid_out=0
  - a_data_out=0, b_data_out=0
  - a_count_out=0, b_count_out=0
- Reset mid-operation discards held data; no handshake completes on a reset cycle. ready_out is 0 while rst_in=1.
- Per channel X, state is full_X (= X_valid_out) plus data_X. The channel behaves as a two-state FSM:
  - EMPTY -> FULL on fill.
  - FULL -> EMPTY on drain without fill.
  - FULL -> FULL on drain with simultaneous fill.
- Drain: X_valid_out && X_ready_in at a rising edge. Increments X_count_out by 1, modulo 2^CNT_WIDTH (wraps 255 -> 0).
- ready_out = ~rst_in && (sel_in ? (~full_B | b_ready_in) : (~full_A | a_ready_in)).
  - Combinational on sel_in, full flags and the selected ready_in only; no dependence on valid_in.
- Accept: valid_in && ready_out at a rising edge. Fills channel sel_in with data_in; data visible on X_data_out the next cycle (latency 1).
- Simultaneous drain and fill on the same channel: new data loads, full stays 1, counter increments.
- Channels are independent:
  - A full and stalled does not block transfers with sel_in=1, and vice versa.
  - The non-selected channel can drain in the same cycle a fill occurs on the other channel.
- Holding rules:
  - While X_valid_out=1 and X_ready_in=0, X_data_out and X_valid_out hold stable.
  - Data registers change only on fill or reset.
- sel_in changing while valid_in=1 and not accepted: ready_out follows the new sel_in immediately; no state change.
- valid_in=0: no fill regardless of sel_in/ready_out.
- Throughput: one transfer per cycle sustained when the selected consumer holds ready_in=1.

Test Plan:
- Reset, then idle -> all outputs 0, ready_out=1 (both empty).
- valid_in=1, sel_in=0, data_in=0x5A for one cycle, a_ready_in=0 -> next cycle:
  - a_valid_out=1, a_data_out=0x5A, b_valid_out=0
  - ready_out=0 while sel_in=0; ready_out=1 when sel_in=1.
- Channel A held full, a_ready_in=0; send 0x11,0x22 with sel_in=1 and b_ready_in=1 on consecutive cycles:
  - b_data_out shows 0x11 then 0x22
  - b_count_out ends at 2
  - a_data_out stays 0x5A, a_count_out=0.
- Channel A full, a_ready_in=1 and valid_in=1, sel_in=0, data_in=0x33 in the same cycle:
  - next cycle a_valid_out=1, a_data_out=0x33, a_count_out incremented by 1.
- Stream 257 bytes to B with b_ready_in=1 continuously -> b_count_out wraps to 1; no cycle with ready_out=0.
- Both channels full, assert rst_in for one cycle with valid_in=1 -> next cycle:
  - both valid_out=0, data 0, counters 0
  - the byte presented during reset is not captured.
